// File: rtl/key_press_conditioner.sv
// Push-button conditioner: synchronizes an active-low raw key, debounces it with a
// four-state FSM and emits registered press/release/long-press strobes and a press count.
module key_press_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000
) (
  input  logic       MAX10_CLK1_50,
  input  logic       KEY0,
  input  logic       KEY1,
  output logic       key_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [7:0] press_count
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int LW = $clog2(LONG_CYCLES);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DB_ONE    = DW'(1);
  localparam logic [LW-1:0] HOLD_LAST = LW'(LONG_CYCLES - 1);
  localparam logic [LW-1:0] HOLD_PRE  = LW'(LONG_CYCLES - 2);
  localparam logic [LW-1:0] HOLD_ONE  = LW'(1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            sync1_q;
  logic            k_s_q;
  logic [DW-1:0]   db_cnt_q, db_cnt_d;
  logic [LW-1:0]   hold_cnt_q, hold_cnt_d;
  logic            long_flag_q, long_flag_d;
  logic            key_level_q, key_level_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            long_q, long_d;
  logic [7:0]      count_q, count_d;

  // KEY1 is active-low and asynchronous; invert before the two-flop synchronizer.
  always_ff @(posedge MAX10_CLK1_50 or negedge KEY0) begin
    if (!KEY0) begin
      sync1_q <= 1'b0;
      k_s_q   <= 1'b0;
    end else begin
      sync1_q <= ~KEY1;
      k_s_q   <= sync1_q;
    end
  end

  always_ff @(posedge MAX10_CLK1_50 or negedge KEY0) begin
    if (!KEY0) begin
      state_q     <= IDLE;
      db_cnt_q    <= '0;
      hold_cnt_q  <= '0;
      long_flag_q <= 1'b0;
      key_level_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      count_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      long_flag_q <= long_flag_d;
      key_level_q <= key_level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      count_q     <= count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    long_flag_d = long_flag_q;
    key_level_d = key_level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    count_d     = count_q;

    // Hold time runs through RELEASE_WAIT so a long press can still be reported
    // while a release is being debounced; a glitch back to HELD keeps it.
    if (state_q == HELD || state_q == RELEASE_WAIT) begin
      if (hold_cnt_q != HOLD_LAST) begin
        hold_cnt_d = hold_cnt_q + HOLD_ONE;
      end
      if (hold_cnt_q == HOLD_PRE && !long_flag_q) begin
        long_d      = 1'b1;
        long_flag_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (k_s_q) begin
          state_d  = PRESS_WAIT;
          db_cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (!k_s_q) begin
          state_d = IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = HELD;
          press_d     = 1'b1;
          key_level_d = 1'b1;
          count_d     = count_q + 8'd1;
          hold_cnt_d  = '0;
          long_flag_d = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end
      HELD: begin
        if (!k_s_q) begin
          state_d  = RELEASE_WAIT;
          db_cnt_d = '0;
        end
      end
      RELEASE_WAIT: begin
        if (k_s_q) begin
          state_d = HELD;
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = IDLE;
          release_d   = 1'b1;
          key_level_d = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign key_level     = key_level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign press_count   = count_q;

endmodule

// File: tb/tb_key_press_conditioner.sv
// Directed bench for key_press_conditioner: the driver queues each expected strobe with
// its cycle, count and level; a negedge monitor pops and compares whenever a strobe appears.
module tb_key_press_conditioner;

  localparam int DB = 4;
  localparam int LC = 20;
  localparam int W  = 28;  // {kind[2:0], cycle[15:0], count[7:0], level}
  localparam int PRESS_LAT = DB + 3;
  localparam int LONG_LAT  = DB + 3 + LC - 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key1;
  logic       key_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic [7:0] press_count;

  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0] exp_count;
  logic [W-1:0] mon_exp;
  logic [W-1:0] mon_act;
  logic [2:0]   mon_kind;
  int         t;

  key_press_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES    (LC)
  ) dut (
    .MAX10_CLK1_50(clk),
    .KEY0         (rst_n),
    .KEY1         (key1),
    .key_level    (key_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .press_count  (press_count)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] pack_ev(logic [2:0] kind, int at, logic [7:0] cnt, logic lvl);
    return {kind, 16'(at), cnt, lvl};
  endfunction

  task automatic push_press(int at);
    exp_count = exp_count + 8'd1;
    exp_q.push_back(pack_ev(3'b001, at, exp_count, 1'b1));
  endtask

  task automatic push_release(int at);
    exp_q.push_back(pack_ev(3'b010, at, exp_count, 1'b0));
  endtask

  task automatic push_long(int at);
    exp_q.push_back(pack_ev(3'b100, at, exp_count, 1'b1));
  endtask

  task automatic drive(logic lvl, int n);
    key1 = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    mon_kind = {long_pulse, release_pulse, press_pulse};
    if (mon_kind != 3'b000) begin
      checks++;
      mon_act = pack_ev(mon_kind, cyc, press_count, key_level);
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse actual=%0h expected=none", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          failures++;
          $display("FAIL pulse_event actual=%0h expected=%0h", mon_act, mon_exp);
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0][24:9] < cyc[15:0]) begin
      checks++;
      failures++;
      mon_exp = exp_q.pop_front();
      $display("FAIL missed_pulse actual=none expected=%0h", mon_exp);
    end
  end

  task automatic check_all_zero(string tag);
    check({tag, "_key_level"}, key_level, 0);
    check({tag, "_press"}, press_pulse, 0);
    check({tag, "_release"}, release_pulse, 0);
    check({tag, "_long"}, long_pulse, 0);
    check({tag, "_count"}, press_count, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    key1 = 1'b1;
    exp_count = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    drive(1'b1, 5);

    // clean press then release
    t = cyc; push_press(t + PRESS_LAT);
    drive(1'b0, 10);
    check("clean_level_held", key_level, 1);
    t = cyc; push_release(t + PRESS_LAT);
    drive(1'b1, 12);
    check("clean_level_released", key_level, 0);
    check("clean_count", press_count, 32'(exp_count));

    // bounce shorter than the debounce window
    drive(1'b0, 3);
    drive(1'b1, 2);
    drive(1'b0, 3);
    drive(1'b1, 12);
    check("bounce_level", key_level, 0);
    check("bounce_count", press_count, 32'(exp_count));

    // long press: one long strobe, no repeat
    t = cyc; push_press(t + PRESS_LAT); push_long(t + LONG_LAT);
    drive(1'b0, 40);
    t = cyc; push_release(t + PRESS_LAT);
    drive(1'b1, 12);

    // release glitch while held; hold time keeps running across it
    t = cyc; push_press(t + PRESS_LAT); push_long(t + LONG_LAT);
    drive(1'b0, 12);
    drive(1'b1, 2);
    drive(1'b0, 4);
    check("glitch_level", key_level, 1);
    drive(1'b0, 16);
    check("glitch_level_late", key_level, 1);
    t = cyc; push_release(t + PRESS_LAT);
    drive(1'b1, 12);

    // long limit reached on the same edge the release is accepted
    t = cyc; push_press(t + PRESS_LAT);
    exp_q.push_back(pack_ev(3'b110, t + LONG_LAT, exp_count, 1'b0));
    drive(1'b0, 19);
    drive(1'b1, 15);

    // reset in HELD, key still down afterwards
    t = cyc; push_press(t + PRESS_LAT);
    drive(1'b0, 12);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    drive(1'b0, 3);
    rst_n = 1'b1;
    exp_count = 8'd0;
    t = cyc; push_press(t + PRESS_LAT);
    drive(1'b0, 12);
    check("repress_count", press_count, 1);
    t = cyc; push_release(t + PRESS_LAT);
    drive(1'b1, 12);

    // 255 more presses wrap the count back to zero
    for (int i = 0; i < 255; i++) begin
      t = cyc; push_press(t + PRESS_LAT);
      drive(1'b0, 8);
      t = cyc; push_release(t + PRESS_LAT);
      drive(1'b1, 9);
    end
    check("wrap_count", press_count, 0);
    check("wrap_level", key_level, 0);

    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_press_conditioner.md
KEY_PRESS_CONDITIONER -- requirements
Module: key_press_conditioner

Interface
REQ-001 The block SHALL expose parameter DEBOUNCE_CYCLES, default 1000000 (20 ms at 50 MHz): the number of cycles the synchronized key must hold a new level before that level is accepted.
REQ-002 The block SHALL expose parameter LONG_CYCLES, default 50000000 (1 s at 50 MHz): accepted-press duration that produces a long-press event.
REQ-003 The block SHALL have port MAX10_CLK1_50, input, 1 bit: the single clock; every register is clocked on its rising edge.
REQ-004 The block SHALL have port KEY0, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port KEY1, input, 1 bit: raw push-button, asynchronous to the clock, active-low (0 = pressed).
REQ-006 The block SHALL have port key_level, output, 1 bit: debounced pressed level, 1 = pressed.
REQ-007 The block SHALL have port press_pulse, output, 1 bit: one-cycle strobe when a press is accepted.
REQ-008 The block SHALL have port release_pulse, output, 1 bit: one-cycle strobe when a release is accepted.
REQ-009 The block SHALL have port long_pulse, output, 1 bit: one-cycle strobe when an accepted press reaches LONG_CYCLES.
REQ-010 The block SHALL have port press_count, output, 8 bits: count of accepted presses.

Function
REQ-011 KEY1 SHALL be inverted and passed through a 2-flop synchronizer; the second flop output is k_s, and only k_s SHALL drive the logic below.
REQ-012 The FSM states SHALL be IDLE, PRESS_WAIT, HELD and RELEASE_WAIT.
REQ-013 IDLE: k_s=1 -> PRESS_WAIT, debounce counter cleared to 0; otherwise stay.
REQ-014 PRESS_WAIT: k_s=0 -> IDLE with no pulse; otherwise increment the counter, and on the cycle the counter equals DEBOUNCE_CYCLES-1 go to HELD.
REQ-015 On entering HELD from PRESS_WAIT: press_pulse=1 for exactly one cycle, key_level<=1, press_count increments modulo 256 (255 -> 0), hold counter and long flag cleared.
REQ-016 HELD: hold counter increments every cycle and saturates at LONG_CYCLES-1.
REQ-017 In HELD, when the hold counter reaches LONG_CYCLES-1 with the long flag clear: long_pulse=1 for one cycle and the long flag is set; long_pulse asserts at most once per accepted press.
REQ-018 HELD: k_s=0 -> RELEASE_WAIT, debounce counter cleared.
REQ-019 RELEASE_WAIT: k_s=1 -> back to HELD with no pulse; the hold counter and long flag are preserved, not reset.
REQ-020 RELEASE_WAIT otherwise: increment the counter; on the cycle it equals DEBOUNCE_CYCLES-1 go to IDLE, release_pulse=1 for one cycle, key_level<=0.
REQ-021 The hold counter SHALL keep counting in RELEASE_WAIT, so long_pulse can fire there if the limit is reached before the release is accepted.
REQ-022 All outputs SHALL be registered; press_pulse, release_pulse and long_pulse SHALL never be high in the same cycle, except that long_pulse may coincide with release_pulse in RELEASE_WAIT when both conditions occur on the same edge.
REQ-023 Latency: KEY1 held low continuously from the first sampling edge E SHALL give press_pulse high in the cycle after edge E+DEBOUNCE_CYCLES+2; release latency is symmetric.
REQ-024 Any bounce shorter than DEBOUNCE_CYCLES cycles (at k_s) SHALL produce no pulse and no change on key_level.
REQ-025 Counters SHALL be sized by clog2 of their parameter; DEBOUNCE_CYCLES>=2 and LONG_CYCLES>DEBOUNCE_CYCLES are required, and other values are unsupported.

Reset
REQ-026 KEY0=0 SHALL immediately force: FSM=IDLE, synchronizer flops=0, all counters=0, long flag=0, key_level=0, all pulses=0, press_count=0.
REQ-027 Reset asserted mid-press (any state) SHALL discard the press in progress and emit no release_pulse.
REQ-028 After KEY0 returns to 1 with KEY1 already low, a fresh press SHALL be accepted via PRESS_WAIT with the full latency of REQ-023.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20)
REQ-029 Clean press: KEY1 low for 10 cycles then high -> press_pulse one cycle at E+6; press_count=1; key_level=1 until release_pulse at release edge +6.
REQ-030 Bounce: KEY1 low 3 cycles, high 2, low 3, high -> no pulses, key_level=0, press_count=0.
REQ-031 Long press: KEY1 low 40 cycles -> press_pulse once, then long_pulse once 19 cycles later, then release_pulse; no second long_pulse.
REQ-032 Release glitch: while HELD, KEY1 high 2 cycles then low -> no release_pulse; key_level stays 1; hold count continues.
REQ-033 Wrap: 256 clean presses -> press_count returns to 0 after the 256th press_pulse.
REQ-034 Reset mid-hold: assert KEY0 in HELD -> all outputs 0 immediately, no release_pulse; KEY1 held low after reset -> press_pulse at full latency, press_count=1.
